// File: rtl/miriscv_mem_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side signals around miriscv_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core and memory.
interface miriscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              instr_req_i;
  logic [XLEN-1:0]   instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [XLEN-1:0]   instr_rdata_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [XLEN/8-1:0] data_be_i;
  logic [XLEN-1:0]   data_addr_i;
  logic [XLEN-1:0]   data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [XLEN-1:0]   data_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  logic              spurious_rsp_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output spurious_rsp_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  spurious_rsp_o
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory port between fetch and LSU; an in-order owner queue routes responses back.
// Define MIRISCV_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over instr.
module miriscv_mem_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int XLEN        = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  miriscv_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  logic [OUTSTANDING-1:0] owner_reg, owner_next;
  logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]       count_reg, count_next;

  logic              full;
  logic              data_wins;
  logic              mem_req;
  logic              grant;
  logic              pop;
  logic              head_owner;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;

  // Full comes from the registered count only, so a response never frees a slot combinationally.
  assign full    = (count_reg == CNT_MAX);
  assign mem_req = (bus.instr_req_i | bus.data_req_i) & ~full;
  assign grant   = mem_req & bus.mem_gnt_i;

`ifdef MIRISCV_ARB_RR_EN
  logic last_data_reg, last_data_next;

  // Under contention the side that did not win the previous grant goes first.
  assign data_wins = bus.data_req_i & (~bus.instr_req_i | ~last_data_reg);

  always_comb begin
    last_data_next = last_data_reg;
    if (grant) begin
      last_data_next = data_wins;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_data_reg <= 1'b0;
    end else begin
      last_data_reg <= last_data_next;
    end
  end
`else
  assign data_wins = bus.data_req_i;
`endif

  // With no requester at all the memory fields idle at zero rather than showing the instr defaults.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (data_wins) begin
      mem_we    = bus.data_we_i;
      mem_be    = bus.data_be_i;
      mem_addr  = bus.data_addr_i;
      mem_wdata = bus.data_wdata_i;
    end else if (bus.instr_req_i) begin
      mem_be    = '1;
      mem_addr  = bus.instr_addr_i;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.instr_gnt_o = grant & ~data_wins;
  assign bus.data_gnt_o  = grant & data_wins;

  assign pop        = bus.mem_rvalid_i & (count_reg != '0);
  assign head_owner = owner_reg[rd_ptr_reg];

  assign bus.instr_rvalid_o = pop & ~head_owner;
  assign bus.data_rvalid_o  = pop & head_owner;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.spurious_rsp_o = bus.mem_rvalid_i & (count_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < OUTSTANDING; gi++) begin : g_owner
      assign owner_next[gi] = (grant && (wr_ptr_reg == PTR_W'(gi))) ? data_wins : owner_reg[gi];
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (grant) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({grant, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entries are only meaningful below count, so the payload needs no reset.
  always_ff @(posedge clk_i) begin
    owner_reg <= owner_next;
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter: one instance with 2 outstanding slots, one with 4.
// Both instances see the same stimulus; each test checks the instance it is written for.
module tb_miriscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ireq = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dreq = 1'b0;
  logic        dwe = 1'b0;
  logic [3:0]  dbe = '0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic        mgnt = 1'b0;
  logic        mrvalid = 1'b0;
  logic [31:0] mrdata = '0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  miriscv_mem_arbiter_if #(.XLEN(32)) bus2 ();
  miriscv_mem_arbiter_if #(.XLEN(32)) bus4 ();

  assign bus2.instr_req_i  = ireq;
  assign bus2.instr_addr_i = iaddr;
  assign bus2.data_req_i   = dreq;
  assign bus2.data_we_i    = dwe;
  assign bus2.data_be_i    = dbe;
  assign bus2.data_addr_i  = daddr;
  assign bus2.data_wdata_i = dwdata;
  assign bus2.mem_gnt_i    = mgnt;
  assign bus2.mem_rvalid_i = mrvalid;
  assign bus2.mem_rdata_i  = mrdata;

  assign bus4.instr_req_i  = ireq;
  assign bus4.instr_addr_i = iaddr;
  assign bus4.data_req_i   = dreq;
  assign bus4.data_we_i    = dwe;
  assign bus4.data_be_i    = dbe;
  assign bus4.data_addr_i  = daddr;
  assign bus4.data_wdata_i = dwdata;
  assign bus4.mem_gnt_i    = mgnt;
  assign bus4.mem_rvalid_i = mrvalid;
  assign bus4.mem_rdata_i  = mrdata;

  miriscv_mem_arbiter #(.OUTSTANDING(2), .XLEN(32)) u_dut2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus2)
  );

  miriscv_mem_arbiter #(.OUTSTANDING(4), .XLEN(32)) u_dut4 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a few ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0] exp_d;

  initial begin
`ifdef MIRISCV_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif

    // Reset state and the idle cycle after it
    tick();
    #3;
    check_val("rst_mem_req", {31'd0, bus2.mem_req_o}, 32'd0);
    check_val("rst_mem_be", {28'd0, bus2.mem_be_o}, 32'd0);
    check_val("rst_gnts", {30'd0, bus2.instr_gnt_o, bus2.data_gnt_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    #3;
    check_val("post_rst_outs", {26'd0, bus2.mem_req_o, bus2.mem_we_o, bus2.instr_rvalid_o,
              bus2.data_rvalid_o, bus2.spurious_rsp_o, |bus2.mem_be_o}, 32'd0);
    check_val("post_rst_addr", bus2.mem_addr_o, 32'd0);

    // Single fetch
    tick();
    ireq = 1'b1; iaddr = 32'h100; mgnt = 1'b1;
    #3;
    check_val("fetch_gnt", {30'd0, bus2.instr_gnt_o, bus2.data_gnt_o}, 32'd2);
    check_val("fetch_addr", bus2.mem_addr_o, 32'h100);
    check_val("fetch_be_we", {27'd0, bus2.mem_be_o, bus2.mem_we_o}, 32'h1E);
    tick();
    ireq = 1'b0; mgnt = 1'b0;
    tick();
    mrvalid = 1'b1; mrdata = 32'h0000_0013;
    #3;
    check_val("fetch_rvalid", {29'd0, bus2.instr_rvalid_o, bus2.data_rvalid_o, bus2.spurious_rsp_o}, 32'd4);
    check_val("fetch_rdata", bus2.instr_rdata_o, 32'h13);
    tick();
    mrvalid = 1'b0;

    // Contention on the 4-deep instance
    ireq = 1'b1; iaddr = 32'h104; dreq = 1'b1; dwe = 1'b0; dbe = 4'hF; daddr = 32'h300; mgnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      check_val($sformatf("cont_gnt%0d", k), {30'd0, bus4.data_gnt_o, bus4.instr_gnt_o},
                exp_d[k] ? 32'd2 : 32'd1);
      check_val($sformatf("cont_addr%0d", k), bus4.mem_addr_o, exp_d[k] ? 32'h300 : 32'h104);
      tick();
    end
    ireq = 1'b0; dreq = 1'b0; mgnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mrvalid = 1'b1; mrdata = 32'hA0 + k;
      #3;
      check_val($sformatf("cont_rsp%0d", k), {30'd0, bus4.data_rvalid_o, bus4.instr_rvalid_o},
                exp_d[k] ? 32'd2 : 32'd1);
      tick();
    end
    mrvalid = 1'b0;

    // Full on the 2-deep instance
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h400; mgnt = 1'b1;
    #3;
    check_val("full_gnt0", {31'd0, bus2.data_gnt_o}, 32'd1);
    tick();
    #3;
    check_val("full_gnt1", {31'd0, bus2.data_gnt_o}, 32'd1);
    tick();
    mrvalid = 1'b1; mrdata = 32'h55;
    #3;
    check_val("full_blocked", {29'd0, bus2.mem_req_o, bus2.data_gnt_o, bus2.instr_gnt_o}, 32'd0);
    check_val("full_rsp", {31'd0, bus2.data_rvalid_o}, 32'd1);
    tick();
    mrvalid = 1'b0;
    #3;
    check_val("full_regrant", {31'd0, bus2.data_gnt_o}, 32'd1);
    tick();
    dreq = 1'b0; mgnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mrvalid = 1'b1;
      #3;
      if (k < 2) begin
        check_val($sformatf("full_drain%0d", k), {30'd0, bus2.data_rvalid_o, bus2.spurious_rsp_o}, 32'd2);
      end else begin
        check_val($sformatf("full_drain%0d", k), {30'd0, bus2.data_rvalid_o, bus2.spurious_rsp_o}, 32'd1);
      end
      tick();
    end
    mrvalid = 1'b0;

    // Back-pressure: store held while memory refuses
    dreq = 1'b1; dwe = 1'b1; dbe = 4'hF; daddr = 32'h200; dwdata = 32'hDEAD_BEEF; mgnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      check_val($sformatf("bp_nognt%0d", k), {29'd0, bus2.mem_req_o, bus2.data_gnt_o, bus2.mem_we_o}, 32'd5);
      check_val($sformatf("bp_wdata%0d", k), bus2.mem_wdata_o, 32'hDEAD_BEEF);
      check_val($sformatf("bp_addr%0d", k), bus2.mem_addr_o, 32'h200);
      tick();
    end
    mgnt = 1'b1;
    #3;
    check_val("bp_gnt", {31'd0, bus2.data_gnt_o}, 32'd1);
    tick();
    dreq = 1'b0; mgnt = 1'b0; dwe = 1'b0;
    mrvalid = 1'b1;
    #3;
    check_val("bp_rsp", {29'd0, bus2.instr_rvalid_o, bus2.data_rvalid_o, bus2.spurious_rsp_o}, 32'd2);
    tick();

    // Spurious response: queue now empty
    #3;
    check_val("spur_pulse", {29'd0, bus2.instr_rvalid_o, bus2.data_rvalid_o, bus2.spurious_rsp_o}, 32'd1);
    tick();
    mrvalid = 1'b0;
    #3;
    check_val("spur_clear", {31'd0, bus2.spurious_rsp_o}, 32'd0);

    // Reset with two fetches in flight
    ireq = 1'b1; iaddr = 32'h180; mgnt = 1'b1;
    #3;
    check_val("rstmid_gnt0", {31'd0, bus2.instr_gnt_o}, 32'd1);
    tick();
    #3;
    check_val("rstmid_gnt1", {31'd0, bus2.instr_gnt_o}, 32'd1);
    tick();
    ireq = 1'b0; mgnt = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mrvalid = 1'b1;
      #3;
      check_val($sformatf("rstmid_rsp%0d", k),
                {29'd0, bus2.instr_rvalid_o, bus2.data_rvalid_o, bus2.spurious_rsp_o}, 32'd1);
      check_val($sformatf("rstmid_rsp4_%0d", k),
                {29'd0, bus4.instr_rvalid_o, bus4.data_rvalid_o, bus4.spurious_rsp_o}, 32'd1);
      tick();
    end
    mrvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/miriscv_mem_arbiter.md
# miriscv_mem_arbiter

Shares the core's single memory port between the fetch unit (instruction side) and the load/store unit (data side). Each cycle it arbitrates between the two requesters and forwards the winner's request to memory. It keeps an in-order owner queue of outstanding transactions and uses it to route each memory response back to the requester that issued it. It sits between `miriscv_core` and the top-level memory interface.

## Interface
Parameters:
- `OUTSTANDING`, 2 — maximum number of accepted, not yet answered transactions (1..4)

Ports:
- `clk_i` in 1 — clock; everything updates on the rising edge
- `rst_i` in 1 — synchronous, active-high reset
- `instr_req_i` in 1 — fetch request
- `instr_addr_i` in XLEN — fetch address
- `instr_gnt_o` out 1 — fetch request accepted this cycle
- `instr_rvalid_o` out 1 — fetch response valid
- `instr_rdata_o` out XLEN — fetch response data
- `data_req_i` in 1 — LSU request
- `data_we_i` in 1 — LSU write enable
- `data_be_i` in XLEN/8 — LSU byte enables
- `data_addr_i` in XLEN — LSU address
- `data_wdata_i` in XLEN — LSU write data
- `data_gnt_o` out 1 — LSU request accepted this cycle
- `data_rvalid_o` out 1 — LSU response valid (reads and writes)
- `data_rdata_o` out XLEN — LSU response data
- `mem_req_o` out 1 — memory request
- `mem_we_o` out 1 — memory write enable
- `mem_be_o` out XLEN/8 — memory byte enables
- `mem_addr_o` out XLEN — memory address
- `mem_wdata_o` out XLEN — memory write data
- `mem_gnt_i` in 1 — memory accepts `mem_req_o` this cycle
- `mem_rvalid_i` in 1 — memory response valid; responses return in request order
- `mem_rdata_i` in XLEN — memory response data
- `spurious_rsp_o` out 1 — one-cycle pulse: `mem_rvalid_i` arrived with no outstanding transaction

## Operation
- **Owner queue:** a FIFO, `OUTSTANDING` entries, each 1 bit (0 = instr, 1 = data), with a count register of width clog2(`OUTSTANDING`+1).
- **Full:** `full = (count == OUTSTANDING)`. While full, `mem_req_o` = 0 and both grants are 0.
- **Arbitration winner** (combinational):
  - only one requester asserting: that requester wins;
  - both asserting: the data side wins (fixed priority; see Configuration).
- **Request path:** `mem_req_o = (instr_req_i | data_req_i) & ~full`.
  - `mem_addr_o` / `mem_we_o` / `mem_be_o` / `mem_wdata_o` are muxed from the winner.
  - For an instr winner: `mem_we_o` = 0, `mem_be_o` = all ones, `mem_wdata_o` = 0.
- **Grant:** `<winner>_gnt_o = mem_req_o & mem_gnt_i`. The loser's grant is 0. The loser must hold its request stable until it is granted.
- **Push:** on a grant, the winner ID is pushed into the owner queue.
- **Response routing:**
  - On `mem_rvalid_i` with count > 0, the head entry selects the destination: `instr_rvalid_o` or `data_rvalid_o` = 1. The head is popped.
  - `mem_rdata_i` drives both `instr_rdata_o` and `data_rdata_o` unconditionally.
  - On `mem_rvalid_i` with count == 0: both rvalid outputs stay 0, `spurious_rsp_o` = 1, and the response is dropped.
- **Push and pop in the same cycle:** count is unchanged and both pointers advance. Full is evaluated on the registered count, so a response arriving while full does not unblock a grant until the next cycle.
- **Pointer wrap:** read and write pointers wrap modulo `OUTSTANDING`.
- **Reset (including mid-operation):** count, both pointers and the RR pointer are cleared. Responses to transactions issued before reset are then reported as spurious and dropped.

## Timing
- Arbitration and grant are zero-latency: a request can be granted in the same cycle it is raised.
- Response routing is combinational: `*_rvalid_o` asserts in the same cycle as `mem_rvalid_i`.
- Sustained throughput is one grant per cycle while not full and `mem_gnt_i` = 1.
- There is no combinational path from `mem_rvalid_i` to `mem_req_o` or to either grant.
- Values during reset and in the cycle after, with all inputs at 0: every output is 0.

## Configuration
- **`MIRISCV_ARB_RR_EN` defined:** round-robin arbitration.
  - A 1-bit last-grant register is updated on every grant.
  - When both sides request, the side not granted last wins.
  - The register resets to "instr last", so the first contended grant goes to data.
- **Undefined:** fixed data-over-instr priority; no last-grant register exists.

## Test plan
- **Single fetch:** `instr_req_i`=1, addr 0x100, `mem_gnt_i`=1; `mem_rvalid_i` 2 cycles later with rdata 0x00000013 → `instr_gnt_o`=1 in cycle 0; `instr_rvalid_o`=1 with rdata 0x13; `data_rvalid_o`=0.
- **Contention:** both sides request every cycle for 4 cycles, `mem_gnt_i`=1, `OUTSTANDING`=4.
  - Fixed priority: grant order D,D,D,D.
  - RR: grant order D,I,D,I.
  - Responses are routed in the same order.
- **Full:** `OUTSTANDING`=2, two granted requests and no response → third cycle has `mem_req_o`=0 and no grants. After one `mem_rvalid_i`, a grant occurs the following cycle.
- **Back-pressure:** `mem_gnt_i`=0 for 3 cycles with `data_req_i`=1 (store 0xDEADBEEF to 0x200, be 0xF) → no grant, count stays 0, memory outputs stable. Grant occurs on the first `mem_gnt_i`=1.
- **Spurious response:** `mem_rvalid_i`=1 with count 0 → `spurious_rsp_o` pulses for 1 cycle; both rvalid outputs stay 0.
- **Reset mid-flight:** 2 outstanding transactions, assert `rst_i` for 1 cycle, then 2 responses → both responses flagged spurious; no rvalid to either side.
